fp_mult_normalizer: RTL and testbench

Downstream stage of the single-precision multiplier unit. Consumes the raw sign, biased exponent sum and 48-bit mantissa product, and returns a packed IEEE 754 binary32 result with exception flags. The multiplier keeps the combinational mantissa and exponent datapath; this block adds normalisation, rounding, overflow/underflow handling and special-case selection. It is a 2-stage pipeline with valid/ready handshakes on both sides.

---
 rtl/fpu_pkg.sv | 31 +++
 rtl/fp_round_decide.sv | 27 ++
 rtl/fp_mult_normalizer.sv | 162 ++++++++++++++++
 tb/tb_fp_mult_normalizer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU operand classes, rounding modes and binary32 constants
package fpu_pkg;

    typedef enum logic [2:0] {
        FP_NORMAL  = 3'd0,
        FP_ZERO    = 3'd1,
        FP_INF     = 3'd2,
        FP_NAN     = 3'd3,
        FP_INVALID = 3'd4
    } fp_class_t;

    typedef enum logic [1:0] {
        RM_RNE = 2'd0,
        RM_RTZ = 2'd1,
        RM_RUP = 2'd2,
        RM_RDN = 2'd3
    } rmode_t;

    localparam int          BIAS       = 127;
    localparam int          EXP_MAX    = 255;
    localparam logic [31:0] QNAN       = 32'h7FC00000;
    localparam logic [31:0] POS_INF    = 32'h7F800000;
    localparam logic [31:0] MAX_FINITE = 32'h7F7FFFFF;

    // out_flags = {invalid, overflow, underflow, inexact}
    localparam int FLAG_INVALID   = 3;
    localparam int FLAG_OVERFLOW  = 2;
    localparam int FLAG_UNDERFLOW = 1;
    localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/fp_round_decide.sv
// rtl/fp_round_decide.sv - rounding increment and inexact decision for one significand
module fp_round_decide
    import fpu_pkg::*;
(
    input  logic       lsb,
    input  logic       rnd,
    input  logic       sticky,
    input  logic       sign,
    input  logic [1:0] rmode,
    output logic       incr,
    output logic       inexact
);

    always_comb begin
        incr = 1'b0;
        case (rmode_t'(rmode))
            RM_RNE:  incr = rnd & (sticky | lsb);
            RM_RTZ:  incr = 1'b0;
            RM_RUP:  incr = (rnd | sticky) & ~sign;
            RM_RDN:  incr = (rnd | sticky) & sign;
            default: incr = 1'b0;
        endcase
    end

    assign inexact = rnd | sticky;

endmodule

// File: rtl/fp_mult_normalizer.sv
// rtl/fp_mult_normalizer.sv - 2-stage normalise/round/special-case back end of the fp32 multiplier
// Optional FP_NORM_RMODE_EN adds a pipelined rmode input; otherwise round-to-nearest-even.
module fp_mult_normalizer #(
    parameter int          EXP_W  = 10,
    parameter int          PROD_W = 48,
    parameter logic [31:0] QNAN   = 32'h7FC00000
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sign,
    input  logic signed [EXP_W-1:0] in_exp,
    input  logic [PROD_W-1:0]       in_mant,
    input  logic [2:0]              in_class,
`ifdef FP_NORM_RMODE_EN
    input  logic [1:0]              rmode,
`endif
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             out_result,
    output logic [3:0]              out_flags
);
    import fpu_pkg::*;

    localparam logic signed [EXP_W-1:0] EXP_ONE  = EXP_W'(1);
    localparam logic signed [EXP_W-1:0] EXP_ZERO = '0;
    localparam logic signed [EXP_W-1:0] EXP_OVF  = EXP_W'(EXP_MAX);

    logic s1_valid;
    logic s2_valid;
    logic s1_adv;
    logic s2_adv;

    assign s2_adv    = ~s2_valid | out_ready;
    assign s1_adv    = ~s1_valid | s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Stage 1: pick the 23-bit fraction window based on whether the product reached [2,4)
    logic [22:0]             norm_frac;
    logic                    norm_lsb;
    logic                    norm_rnd;
    logic                    norm_sticky;
    logic signed [EXP_W-1:0] norm_exp;

    always_comb begin
        norm_frac   = in_mant[PROD_W-3 -: 23];
        norm_lsb    = in_mant[PROD_W-25];
        norm_rnd    = in_mant[PROD_W-26];
        norm_sticky = |in_mant[PROD_W-27:0];
        norm_exp    = in_exp;
        if (in_mant[PROD_W-1]) begin
            norm_frac   = in_mant[PROD_W-2 -: 23];
            norm_lsb    = in_mant[PROD_W-24];
            norm_rnd    = in_mant[PROD_W-25];
            norm_sticky = |in_mant[PROD_W-26:0];
            norm_exp    = in_exp + EXP_ONE;
        end
    end

    logic                    s1_sign;
    logic [2:0]              s1_class;
    logic [22:0]             s1_frac;
    logic                    s1_lsb;
    logic                    s1_rnd;
    logic                    s1_sticky;
    logic signed [EXP_W-1:0] s1_exp;
`ifdef FP_NORM_RMODE_EN
    logic [1:0]              s1_rmode;
`else
    localparam logic [1:0]   s1_rmode = RM_RNE;
`endif

    // Stage 2: round, range check, class override
    logic                    incr;
    logic                    inexact;
    logic                    carry;
    logic [22:0]             frac_r;
    logic signed [EXP_W-1:0] exp_r;
    logic                    toward_zero;
    logic [31:0]             res_n;
    logic [3:0]              flags_n;

    fp_round_decide u_round_decide (
        .lsb     (s1_lsb),
        .rnd     (s1_rnd),
        .sticky  (s1_sticky),
        .sign    (s1_sign),
        .rmode   (s1_rmode),
        .incr    (incr),
        .inexact (inexact)
    );

    // A carry out of the hidden bit leaves the fraction at zero, so only the exponent moves
    assign {carry, frac_r} = {1'b0, s1_frac} + {23'd0, incr};
    assign exp_r           = s1_exp + {{(EXP_W-1){1'b0}}, carry};

    assign toward_zero = (s1_rmode == RM_RTZ) ||
                         ((s1_rmode == RM_RUP) &&  s1_sign) ||
                         ((s1_rmode == RM_RDN) && !s1_sign);

    always_comb begin
        res_n   = {s1_sign, exp_r[7:0], frac_r};
        flags_n = 4'b0000;
        case (fp_class_t'(s1_class))
            FP_ZERO: res_n = {s1_sign, 31'd0};
            FP_INF:  res_n = {s1_sign, POS_INF[30:0]};
            FP_NAN:  res_n = QNAN;
            FP_INVALID: begin
                res_n                 = QNAN;
                flags_n[FLAG_INVALID] = 1'b1;
            end
            default: begin
                if (exp_r >= EXP_OVF) begin
                    res_n                  = {s1_sign, toward_zero ? MAX_FINITE[30:0] : POS_INF[30:0]};
                    flags_n[FLAG_OVERFLOW] = 1'b1;
                    flags_n[FLAG_INEXACT]  = 1'b1;
                end else if (exp_r <= EXP_ZERO) begin
                    res_n                   = {s1_sign, 31'd0};
                    flags_n[FLAG_UNDERFLOW] = 1'b1;
                    flags_n[FLAG_INEXACT]   = inexact;
                end else begin
                    flags_n[FLAG_INEXACT] = inexact;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s2_valid   <= 1'b0;
            out_result <= 32'd0;
            out_flags  <= 4'd0;
        end else begin
            if (s1_adv) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_sign   <= in_sign;
                    s1_class  <= in_class;
                    s1_frac   <= norm_frac;
                    s1_lsb    <= norm_lsb;
                    s1_rnd    <= norm_rnd;
                    s1_sticky <= norm_sticky;
                    s1_exp    <= norm_exp;
`ifdef FP_NORM_RMODE_EN
                    s1_rmode  <= rmode;
`endif
                end
            end
            if (s2_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    out_result <= res_n;
                    out_flags  <= flags_n;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_normalizer.sv
// tb/tb_fp_mult_normalizer.sv - scoreboard bench for fp_mult_normalizer (default RNE build)
`timescale 1ns/1ps
module tb_fp_mult_normalizer;
    import fpu_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_sign = 1'b0;
    logic signed [9:0] in_exp = '0;
    logic [47:0]       in_mant = '0;
    logic [2:0]        in_class = '0;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [31:0]       out_result;
    logic [3:0]        out_flags;
`ifdef FP_NORM_RMODE_EN
    logic [1:0]        rmode = 2'd0;
`endif

    int checks = 0;
    int failures = 0;
    logic [35:0] exp_q[$];
    bit rand_ready_en = 1'b0;
    bit forced_ready = 1'b1;

    always #5 clk = ~clk;

    always @(negedge clk)
        out_ready = rand_ready_en ? ($urandom_range(0, 9) < 7) : forced_ready;

    fp_mult_normalizer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_mant    (in_mant),
        .in_class   (in_class),
`ifdef FP_NORM_RMODE_EN
        .rmode      (rmode),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic check(string name, logic [35:0] act, logic [35:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference: value-level rounding of mant * 2^(exp-127-46) to 24 significant bits
    function automatic logic [35:0] ref_model(bit s, int e, logic [47:0] m, logic [2:0] c);
        longint unsigned q, r, half;
        int sh, ee;
        bit inx;
        if (c == FP_ZERO)    return {4'b0000, s, 31'h0};
        if (c == FP_INF)     return {4'b0000, s, 31'h7F800000};
        if (c == FP_NAN)     return {4'b0000, 32'h7FC00000};
        if (c == FP_INVALID) return {4'b1000, 32'h7FC00000};
        sh   = m[47] ? 24 : 23;
        ee   = e + (m[47] ? 1 : 0);
        q    = longint'(m) >> sh;
        r    = longint'(m) & ((64'd1 << sh) - 64'd1);
        half = 64'd1 << (sh - 1);
        inx  = (r != 0);
        if (r > half || (r == half && q[0])) q = q + 1;
        if (q == (64'd1 << 24)) begin
            q  = 64'd1 << 23;
            ee = ee + 1;
        end
        if (ee >= 255) return {4'b0101, s, 31'h7F800000};
        if (ee <= 0)   return {3'b001, inx, s, 31'h0};
        return {3'b000, inx, s, ee[7:0], q[22:0]};
    endfunction

    task automatic send(bit s, int e, logic [47:0] m, logic [2:0] c, logic [35:0] expv);
        int n = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = 10'(e);
        in_mant  = m;
        in_class = c;
        forever begin
            #4;
            if (in_ready) begin
                exp_q.push_back(expv);
                @(posedge clk);
                break;
            end
            @(negedge clk);
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=stalled required=accept");
                break;
            end
        end
        #1 in_valid = 1'b0;
    endtask

    task automatic send_rand(bit force_normal);
        bit s;
        int e, k;
        logic [47:0] m;
        logic [2:0] c;
        logic [23:0] a, b;
        s = 1'($urandom);
        if ($urandom_range(0, 2) == 0) e = int'($urandom_range(0, 506)) - 125;
        else                           e = int'($urandom_range(1, 254));
        k = int'($urandom_range(0, 9));
        if (k < 6) begin
            a = {1'b1, 23'($urandom)};
            b = {1'b1, 23'($urandom)};
            m = 48'(a) * 48'(b);
        end else if (k == 6) m = {2'b01, 23'($urandom), 1'b1, 22'd0};
        else if (k == 7)     m = {1'b1, 23'($urandom), 1'b1, 23'd0};
        else if (k == 8)     m = {2'b01, 23'h7FFFFF, 1'b1, 22'($urandom)};
        else                 m = {1'b1, 15'($urandom), 32'($urandom)};
        c = FP_NORMAL;
        if (!force_normal && $urandom_range(0, 19) >= 16) c = 3'($urandom_range(1, 4));
        send(s, e, m, c, ref_model(s, e, m, c));
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("drain_empty", 36'(exp_q.size()), 36'd0);
    endtask

    // Monitor: pops on every output transfer and checks held outputs under backpressure
    bit held = 1'b0;
    logic [35:0] held_val;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                held = 1'b0;
            end else begin
                if (held) begin
                    check("hold_valid", 36'(out_valid), 36'd1);
                    check("hold_stable", {out_flags, out_result}, held_val);
                end
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_output actual=%h required=none", {out_flags, out_result});
                    end else begin
                        check("result", {out_flags, out_result}, exp_q.pop_front());
                    end
                end
                held     = out_valid && !out_ready;
                held_val = {out_flags, out_result};
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #4;
        check("rst_out_valid", 36'(out_valid), 36'd0);
        check("rst_out_result", 36'(out_result), 36'd0);
        check("rst_out_flags", 36'(out_flags), 36'd0);
        check("rst_in_ready", 36'(in_ready), 36'd1);

        send(1'b0, 127, 48'h9000_0000_0000, FP_NORMAL, {4'b0000, 32'h40100000});
        send(1'b0, 127, 48'h4000_0040_0000, FP_NORMAL, {4'b0001, 32'h3F800000});
        send(1'b0, 127, 48'h4000_00C0_0000, FP_NORMAL, {4'b0001, 32'h3F800002});
        send(1'b1, 300, 48'h4000_0000_0000, FP_NORMAL, {4'b0101, 32'hFF800000});
        send(1'b1, -5,  48'h4000_0000_0000, FP_NORMAL, {4'b0010, 32'h80000000});
        send(1'b0, 0,   48'h4000_0000_0000, FP_NORMAL, {4'b0010, 32'h00000000});
        send(1'b0, 1,   48'h4000_0000_0000, FP_NORMAL, {4'b0000, 32'h00800000});
        send(1'b0, 0,   48'h8000_0000_0000, FP_NORMAL, {4'b0000, 32'h00800000});
        send(1'b0, 254, 48'h7FFF_FFC0_0000, FP_NORMAL, {4'b0101, 32'h7F800000});
        send(1'b0, 127, 48'h4000_0000_0000, FP_INVALID, {4'b1000, 32'h7FC00000});
        send(1'b1, 127, 48'h4000_0000_0000, FP_INF,     {4'b0000, 32'hFF800000});
        send(1'b0, 127, 48'h4000_0000_0000, FP_ZERO,    {4'b0000, 32'h00000000});
        send(1'b1, 10,  48'h4000_0000_0000, FP_NAN,     {4'b0000, 32'h7FC00000});
        drain();

        forced_ready = 1'b0;
        @(negedge clk);
        fork
            begin
                for (int i = 0; i < 4; i++) send_rand(1'b1);
            end
            begin
                repeat (3) @(negedge clk);
                #4;
                check("stall_in_ready", 36'(in_ready), 36'd0);
                forced_ready = 1'b1;
            end
        join
        drain();

        send_rand(1'b1);
        send_rand(1'b1);
        @(negedge clk);
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        #4;
        check("midrst_out_valid", 36'(out_valid), 36'd0);
        check("midrst_in_ready", 36'(in_ready), 36'd1);

        rand_ready_en = 1'b1;
        repeat (300) send_rand(1'b0);
        rand_ready_en = 1'b0;
        forced_ready  = 1'b1;
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
